// File: rtl/fp8_accumulator.sv
// fp8_accumulator: sums groups of FP8 (E4M3) products into a saturating
// fixed-point register (units of 2^-9) and presents sum + FP8 re-encoding.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready
// input stream; out_valid/out_ready result handshake; out_sum, out_fp8,
// out_count, out_sat group results.
module fp8_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_fp8,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    typedef enum logic {
        ACCUM,
        RESULT
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             sat;

    logic             beat;
    logic [3:0]       exp_in;
    logic [17:0]      mag;
    logic [ACC_W:0]   val;
    logic [ACC_W:0]   sum;
    logic             clamp;
    logic [ACC_W-1:0] acc_next;
    logic [7:0]       cnt_next;

    logic [ACC_W-1:0] abs_s;
    logic [5:0]       lead;
    logic [5:0]       exp_out;
    logic [ACC_W-1:0] shifted;
    logic [7:0]       fp8_next;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == RESULT);
    assign beat      = in_valid & in_ready;
    assign exp_in    = in_data[6:3];

    // FP8 decode to an unsigned 18-bit magnitude, then sign-apply at ACC_W+1
    always_comb begin
        mag = '0;
        if (exp_in == 4'd0) begin
            mag = {15'd0, in_data[2:0]};
        end else begin
            mag = {14'd0, 1'b1, in_data[2:0]} << (exp_in - 4'd1);
        end
    end

    always_comb begin
        val = {{(ACC_W + 1 - 18){1'b0}}, mag};
        if (in_data[7]) begin
            val = ~val + 1'b1;
        end
    end

    // One guard bit: overflow shows up as the top two bits disagreeing
    assign sum   = {acc[ACC_W-1], acc} + val;
    assign clamp = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (clamp) begin
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // FP8 encode of the post-update sum; truncation, no rounding
    assign abs_s = acc_next[ACC_W-1] ? (~acc_next + 1'b1) : acc_next;

    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (abs_s[i]) begin
                lead = i[5:0];
            end
        end
    end

    assign exp_out = lead - 6'd2;
    assign shifted = abs_s >> (lead - 6'd3);

    always_comb begin
        fp8_next = 8'h00;
        if (abs_s == '0) begin
            fp8_next = 8'h00;
        end else if (abs_s[ACC_W-1:3] == '0) begin
            fp8_next = {acc_next[ACC_W-1], 4'd0, abs_s[2:0]};
        end else if (lead > 6'd17) begin
            fp8_next = {acc_next[ACC_W-1], 7'h7F};
        end else begin
            fp8_next = {acc_next[ACC_W-1], exp_out[3:0], shifted[2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_sum   <= '0;
            out_fp8   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (beat) begin
                        if (in_last) begin
                            out_sum   <= acc_next;
                            out_fp8   <= fp8_next;
                            out_count <= cnt_next;
                            out_sat   <= sat | clamp;
                            acc       <= '0;
                            cnt       <= '0;
                            sat       <= 1'b0;
                            state     <= RESULT;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                            sat <= sat | clamp;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
